divider: RTL and testbench



---
 rtl/divider.sv | 120 ++++++++++++
 tb/tb_divider.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Sequential radix-2 restoring divider, one quotient bit per cycle; `DIVIDER_SIGNED_EN selects two's complement operands.
// Latency WIDTH+1 cycles from accepting edge; start is ignored while busy, results held until the next accepted start.
module divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             finish,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] dvs;

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

`ifdef DIVIDER_SIGNED_EN
    logic dvd_neg;
    logic dvs_neg;

    always_comb begin
        dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
        dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
        q_fix   = (dvd_neg ^ dvs_neg) ? -dq : dq;
        r_fix   = dvd_neg ? -rem : rem;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_neg <= 1'b0;
            dvs_neg <= 1'b0;
        end else if (state == IDLE && start) begin
            dvd_neg <= dividend[WIDTH-1];
            dvs_neg <= divisor[WIDTH-1];
        end
    end
`else
    always_comb begin
        dvd_mag = dividend;
        dvs_mag = divisor;
        q_fix   = dq;
        r_fix   = rem;
    end
`endif

    // Extra MSB on the subtraction acts as the borrow; with a zero divisor the
    // partial remainder simply accumulates the dividend magnitude.
    always_comb begin
        shifted = {rem, dq[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, dvs};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            dq        <= '0;
            dvs       <= '0;
            finish    <= 1'b0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rem      <= '0;
                        dq       <= dvd_mag;
                        dvs      <= dvs_mag;
                        cnt      <= '0;
                        finish   <= 1'b0;
                        div_zero <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (trial[WIDTH+1]) begin
                        rem <= shifted[WIDTH-1:0];
                        dq  <= {dq[WIDTH-2:0], 1'b0};
                    end else begin
                        rem <= trial[WIDTH-1:0];
                        dq  <= {dq[WIDTH-2:0], 1'b1};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= FIX;
                end
                FIX: begin
                    // Remainder after a zero divisor equals the original dividend bits.
                    quotient  <= (dvs == '0) ? '1 : q_fix;
                    remainder <= r_fix;
                    div_zero  <= (dvs == '0);
                    finish    <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: expected results queued at acceptance, compared at finish.
module tb_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         finish;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .finish    (finish),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.dz = (b == '0);
        if (b == '0) begin
            e.q = '1;
            e.r = a;
        end else begin
`ifdef DIVIDER_SIGNED_EN
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.q = 32'h8000_0000;
                e.r = '0;
            end else begin
                e.q = $signed(a) / $signed(b);
                e.r = $signed(a) % $signed(b);
            end
`else
            e.q = a / b;
            e.r = a % b;
`endif
        end
        return e;
    endfunction

    // Called #1 after an edge with the DUT idle; returns #1 after the accepting edge.
    task automatic start_req(input logic [W-1:0] a, input logic [W-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic wait_result(input string tag);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (!finish && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_lat"}, cyc, W + 1);
        check({tag, "_sb"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_q"}, quotient, e.q);
            check({tag, "_r"}, remainder, e.r);
            check({tag, "_dz"}, div_zero, e.dz);
        end
    endtask

    logic [W-1:0] dir_a [6];
    logic [W-1:0] dir_b [6];

    initial begin
        dir_a = '{32'd100, 32'h8000_0005, 32'hFFFF_FFF9, 32'd7,          32'h8000_0000, 32'd50};
        dir_b = '{32'd7,   32'd0,         32'd2,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd5};

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_finish", finish, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dz", div_zero, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            start_req(dir_a[i], dir_b[i]);
            wait_result($sformatf("dir%0d", i));
            repeat (2) @(posedge clk);
            #1;
        end

        // Busy protection: start pulses at N+10 and on the FIX edge are ignored.
        start_req(32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1; dividend = 32'd9; divisor = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (22) @(posedge clk);
        #1;
        check("busy_pre_fix", finish, 0);
        start = 1'b1; dividend = 32'd9; divisor = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_finish", finish, 1);
        check("busy_q", quotient, 14);
        check("busy_r", remainder, 2);
        void'(sb.pop_front());
        repeat (5) @(posedge clk);
        #1;
        check("busy_hold_finish", finish, 1);
        check("busy_hold_q", quotient, 14);
        check("busy_hold_r", remainder, 2);

        // Asynchronous reset mid-run discards the request.
        start_req(32'd100, 32'd7);
        repeat (14) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_finish", finish, 0);
        check("mid_rst_q", quotient, 0);
        check("mid_rst_r", remainder, 0);
        check("mid_rst_dz", div_zero, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_req(32'd50, 32'd5);
        wait_result("post_rst");
        check("post_rst_q10", quotient, 10);

        // Back-to-back: start held high, re-accepted on the edge after finish.
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int   cyc;
            exp_t e;
            dividend = $urandom;
            case (i % 4)
                0:       divisor = '0;
                1:       divisor = $urandom_range(1, 15);
                2:       divisor = $urandom;
                default: divisor = dividend ^ 32'h1;
            endcase
            sb.push_back(model(dividend, divisor));
            @(posedge clk);
            #1;
            check($sformatf("b2b%0d_fall", i), finish, 0);
            cyc = 0;
            while (!finish && cyc < 100) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            check($sformatf("b2b%0d_lat", i), cyc, W + 1);
            e = sb.pop_front();
            check($sformatf("b2b%0d_q", i), quotient, e.q);
            check($sformatf("b2b%0d_r", i), remainder, e.r);
            check($sformatf("b2b%0d_dz", i), div_zero, e.dz);
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold_finish", finish, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
